// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch opcode encodings, branch-class decode
// and the fetch sequencer state encoding.
package cpu_pkg;

    localparam int OPC_W = 6;

    // Branch-class opcodes. They form one contiguous range so that the
    // decode is a simple range compare.
    localparam logic [OPC_W-1:0] BEQ  = 6'b001000;
    localparam logic [OPC_W-1:0] BNE  = 6'b001001;
    localparam logic [OPC_W-1:0] JR   = 6'b001010;
    localparam logic [OPC_W-1:0] BEQZ = 6'b001011;
    localparam logic [OPC_W-1:0] BENZ = 6'b001100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        ISSUE   = 2'd2,
        RESOLVE = 2'd3
    } seq_state_t;

    // True for opcodes whose PC update depends on the ALU result.
    function automatic logic is_branch(input logic [OPC_W-1:0] opcode);
        return (opcode >= BEQ) && (opcode <= BENZ);
    endfunction

endpackage

// File: rtl/branch_target.sv
// Next-PC computation for a resolved branch: Jr jumps to the absolute
// ALU result, every other branch steps by it (8-bit wrapping add).
module branch_target
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [7:0]       pc,
    input  logic [7:0]       br_out,
    output logic [7:0]       next_pc
);

    // Select absolute target or relative step.
    always_comb begin
        next_pc = pc + br_out;
        if (opcode == JR) begin
            next_pc = br_out;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer. Fetches one word at a time over a
// req/ack handshake, issues it to the decoder, and for branch-class words
// waits for the ALU result before choosing the next PC.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int         INSTR_W  = 22,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req,
    output logic [7:0]         imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [7:0]         instr_pc,
    output logic               instr_valid,
    input  logic               br_valid,
    input  logic [7:0]         br_out,
    output logic [7:0]         pc,
    output logic               busy
);

    seq_state_t         r_state;
    logic [7:0]         r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [7:0]         r_instr_pc;
    logic               r_instr_valid;
    logic               r_imem_req;

    logic [OPC_W-1:0]   w_opcode;
    logic [7:0]         w_next_pc;

    // The issued word stays in r_instr through RESOLVE, so its opcode
    // drives both the branch decode and the target computation.
    assign w_opcode = r_instr[INSTR_W-1 -: OPC_W];

    branch_target u_branch_target (
        .opcode  (w_opcode),
        .pc      (r_pc),
        .br_out  (br_out),
        .next_pc (w_next_pc)
    );

    // Sequencer FSM; imem_req and instr_valid are registered alongside
    // the state so they change only on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= 8'h00;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_state    <= FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    // run is deliberately not consulted: a started
                    // handshake always completes.
                    if (imem_ack) begin
                        r_instr       <= imem_data;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (is_branch(w_opcode)) begin
                        r_state <= RESOLVE;
                    end else begin
                        r_pc <= r_pc + 8'd1;
                        if (run) begin
                            r_state    <= FETCH;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                RESOLVE: begin
                    if (br_valid) begin
                        r_pc <= w_next_pc;
                        if (run) begin
                            r_state    <= FETCH;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign busy        = (r_state != IDLE);

endmodule
